// File: rtl/uart_tx_if.sv
// Handshake and serial-output bundle for uart_tx: payload, framing options and line status.
interface uart_tx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      parity_enable;
  logic                      parity_type;
  logic                      TX_OUT_S;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, Prescale, parity_enable, parity_type,
    input  TX_OUT_S, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, Prescale, parity_enable, parity_type,
    output TX_OUT_S, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit,
// each held for Prescale clocks. Outputs are registered from the next-state decode.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input logic     TX_CLK,
  input logic     RST,
  uart_tx_if.slave tx_if
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] edge_reg, edge_next;
  logic [PRESCALE_WIDTH-1:0] period_reg, period_next;
  logic [BIT_W-1:0]          bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]     data_reg, data_next;
  logic                      par_en_reg, par_en_next;
  logic                      par_odd_reg, par_odd_next;
  logic                      tx_reg, tx_next;
  logic                      busy_reg, busy_next;
  logic                      bit_done;

  assign bit_done = (edge_reg == period_reg - PRESCALE_WIDTH'(1));

  always_ff @(posedge TX_CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      edge_reg    <= '0;
      period_reg  <= '0;
      bit_reg     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      edge_reg    <= edge_next;
      period_reg  <= period_next;
      bit_reg     <= bit_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_odd_reg <= par_odd_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    edge_next    = edge_reg + PRESCALE_WIDTH'(1);
    bit_next     = bit_reg;
    period_next  = period_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_odd_next = par_odd_reg;

    case (state_reg)
      IDLE: begin
        edge_next = '0;
        bit_next  = '0;
        if (tx_if.Data_Valid) begin
          state_next   = START;
          data_next    = tx_if.P_DATA;
          period_next  = (tx_if.Prescale == '0) ? PRESCALE_WIDTH'(1) : tx_if.Prescale;
          par_en_next  = tx_if.parity_enable;
          par_odd_next = tx_if.parity_type;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          edge_next  = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          edge_next = '0;
          if (bit_reg == BIT_W'(DATA_WIDTH - 1)) begin
            bit_next   = '0;
            state_next = par_en_reg ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          edge_next  = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          edge_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        edge_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Line level is decoded from the upcoming state so it lands one cycle after acceptance.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_next[bit_next];
      PARITY:  tx_next = (^data_next) ^ par_odd_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_if.TX_OUT_S = tx_reg;
  assign tx_if.busy     = busy_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx against a per-cycle queue model of the serial line.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) bus();

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .TX_CLK(clk),
    .RST   (rst),
    .tx_if (bus)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int busy_cycles   = 0;
  int frames        = 0;

  bit exp_q[$];
  bit exp_tx   = 1'b1;
  bit exp_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line level for every cycle of one frame, from the framing rules.
  function automatic void push_frame(input logic [7:0] d, input int p, input bit pe, input bit po);
    int per  = (p == 0) ? 1 : p;
    int ones = 0;
    for (int k = 0; k < per; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      ones += int'(d[i]);
      for (int k = 0; k < per; k++) exp_q.push_back(d[i]);
    end
    if (pe) for (int k = 0; k < per; k++) exp_q.push_back(bit'((ones % 2) ^ int'(po)));
    for (int k = 0; k < per; k++) exp_q.push_back(1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else if (!exp_busy && bus.Data_Valid) begin
      push_frame(bus.P_DATA, int'(bus.Prescale), bus.parity_enable, bus.parity_type);
      frames++;
      $display("frame %0d: data=%02h prescale=%0d parity_en=%0b parity_odd=%0b",
               frames, bus.P_DATA, bus.Prescale, bus.parity_enable, bus.parity_type);
    end
    if (exp_q.size() > 0) begin
      exp_tx   = exp_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    #1;
    check("tx_out", 32'(bus.TX_OUT_S), 32'(exp_tx));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    if (bus.busy === 1'b1) busy_cycles++;
  endtask

  task automatic set_inputs(input logic [7:0] d, input logic [4:0] p, input bit pe, input bit po);
    bus.P_DATA        = d;
    bus.Prescale      = p;
    bus.parity_enable = pe;
    bus.parity_type   = po;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_busy || bus.busy !== 1'b0) && n < limit) begin
      step();
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'(0));
  endtask

  task automatic send(input logic [7:0] d, input logic [4:0] p, input bit pe, input bit po);
    set_inputs(d, p, pe, po);
    bus.Data_Valid = 1'b1;
    busy_cycles = 0;
    step();
    bus.Data_Valid = 1'b0;
    wait_idle(1000);
  endtask

  initial begin
    set_inputs(8'h00, 5'd0, 1'b0, 1'b0);
    bus.Data_Valid = 1'b1;
    rst = 1'b1;
    step();
    step();
    check("reset_tx", 32'(bus.TX_OUT_S), 32'(1));
    check("reset_busy", 32'(bus.busy), 32'(0));
    bus.Data_Valid = 1'b0;
    rst = 1'b0;

    send(8'hA5, 5'd8, 1'b0, 1'b0);
    check("len_a5_p8", 32'(busy_cycles), 32'(80));
    send(8'hA5, 5'd4, 1'b1, 1'b0);
    check("len_a5_even", 32'(busy_cycles), 32'(44));
    send(8'hA5, 5'd4, 1'b1, 1'b1);
    check("len_a5_odd", 32'(busy_cycles), 32'(44));
    send(8'h07, 5'd3, 1'b1, 1'b0);
    check("len_07_even", 32'(busy_cycles), 32'(33));

    // Mid-frame request with different inputs must be dropped.
    set_inputs(8'h5A, 5'd4, 1'b0, 1'b0);
    bus.Data_Valid = 1'b1;
    busy_cycles = 0;
    step();
    bus.Data_Valid = 1'b0;
    repeat (10) step();
    set_inputs(8'hFF, 5'd16, 1'b1, 1'b1);
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    wait_idle(1000);
    repeat (3) step();
    check("len_ignore_dv", 32'(busy_cycles), 32'(40));

    // Reset in the middle of data bit 3.
    set_inputs(8'hC3, 5'd4, 1'b0, 1'b0);
    bus.Data_Valid = 1'b1;
    step();
    bus.Data_Valid = 1'b0;
    repeat (18) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_tx", 32'(bus.TX_OUT_S), 32'(1));
    check("rst_mid_busy", 32'(bus.busy), 32'(0));
    step();
    send(8'h3C, 5'd2, 1'b1, 1'b1);
    check("len_after_rst", 32'(busy_cycles), 32'(22));

    // Data_Valid held high with the shortest bit periods.
    for (int p = 0; p < 2; p++) begin
      set_inputs(8'h3C, 5'(p), 1'b0, 1'b0);
      bus.Data_Valid = 1'b1;
      busy_cycles = 0;
      repeat (33) step();
      check("len_held_dv", 32'(busy_cycles), 32'(30));
      bus.Data_Valid = 1'b0;
      wait_idle(100);
    end

    for (int c = 0; c < 3000; c++) begin
      set_inputs(8'($urandom), 5'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
      bus.Data_Valid = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    bus.Data_Valid = 1'b0;
    wait_idle(1000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
